// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared FSM state type and default timing constants for key_conditioner.
package key_cond_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: synchronizer + debounce FSM for one key; auto-repeat built only with KEY_REPEAT_EN.
module key_debounce_fsm
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_bad_repeat
        $error("repeat timing parameters must be non-negative");
    end

    key_state_t state;
    logic [CW-1:0] cnt;
    logic [1:0] sync;
    logic pressed;

    // synchronizer resets to released so a key held through reset is re-debounced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else sync <= {sync[0], key_n};
    end

    assign pressed = ~sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: if (pressed) begin
                    state <= PRESS_WAIT;
                    cnt   <= '0;
                end
                PRESS_WAIT: if (!pressed) begin
                    state <= IDLE;
                end else if (cnt == CNT_LAST) begin
                    state       <= HELD;
                    level       <= 1'b1;
                    press_pulse <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                HELD: if (!pressed) begin
                    state <= RELEASE_WAIT;
                    cnt   <= '0;
                end
                RELEASE_WAIT: if (pressed) begin
                    state <= HELD;
                end else if (cnt == CNT_LAST) begin
                    state         <= IDLE;
                    level         <= 1'b0;
                    release_pulse <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(max2(REPEAT_DELAY, 1) - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(max2(REPEAT_PERIOD, 1) - 1);

    if (REPEAT_PERIOD == 0) begin : g_bad_period
        $error("REPEAT_PERIOD must be non-zero");
    end

    logic [RW-1:0] rpt_cnt;
    logic rpt_on;
    logic rpt_first;

    // only a fresh press arms the repeater; a bounce back from RELEASE_WAIT leaves it idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt      <= '0;
            rpt_on       <= 1'b0;
            rpt_first    <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (state == PRESS_WAIT && pressed && cnt == CNT_LAST) begin
                rpt_on    <= 1'b1;
                rpt_first <= 1'b1;
                rpt_cnt   <= '0;
            end else if (state != HELD || !pressed) begin
                rpt_on  <= 1'b0;
                rpt_cnt <= '0;
            end else if (rpt_on) begin
                if (rpt_cnt == (rpt_first ? DLY_LAST : PER_LAST)) begin
                    repeat_pulse <= 1'b1;
                    rpt_first    <= 1'b0;
                    rpt_cnt      <= '0;
                end else begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounced key levels and press/release/repeat pulses for the HPS keys PIO (repeat needs KEY_REPEAT_EN).
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] key_n_i,
    output logic [NUM_KEYS-1:0] keys_export,
    output logic [NUM_KEYS-1:0] key_press_o,
    output logic [NUM_KEYS-1:0] key_release_o,
    output logic [NUM_KEYS-1:0] key_repeat_o
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_fsm (
            .clk          (clk_clk),
            .rst_n        (reset_reset_n),
            .key_n        (key_n_i[k]),
            .level        (keys_export[k]),
            .press_pulse  (key_press_o[k]),
            .release_pulse(key_release_o[k]),
            .repeat_pulse (key_repeat_o[k])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench; expected pulse events are queued at stimulus time and matched as they appear.
module tb_key_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic [3:0] keys_export, key_press, key_release, key_repeat;

    typedef struct {
        int cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rpt;
    } ev_t;

    ev_t exp_q[$];
    ev_t e;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    key_conditioner #(
        .NUM_KEYS       (4),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .key_n_i      (key_n),
        .keys_export  (keys_export),
        .key_press_o  (key_press),
        .key_release_o(key_release),
        .key_repeat_o (key_repeat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every observed pulse cycle must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n && (key_press | key_release | key_repeat) != 4'h0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d press=%h rel=%h rpt=%h required no pulse",
                         cyc, key_press, key_release, key_repeat);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc !== cyc || e.press !== key_press || e.rel !== key_release || e.rpt !== key_repeat) begin
                    bad++;
                    $display("FAIL pulse_event got cyc=%0d press=%h rel=%h rpt=%h required cyc=%0d press=%h rel=%h rpt=%h",
                             cyc, key_press, key_release, key_repeat, e.cyc, e.press, e.rel, e.rpt);
                end
            end
        end
    end

    task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] rp);
        exp_q.push_back('{c, p, r, rp});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        key_n = 4'hF;
        wait_cycles(3);
        total += 4;
        if (keys_export !== 4'h0) begin bad++; $display("FAIL reset_export got=%h required=0", keys_export); end
        if (key_press !== 4'h0) begin bad++; $display("FAIL reset_press got=%h required=0", key_press); end
        if (key_release !== 4'h0) begin bad++; $display("FAIL reset_release got=%h required=0", key_release); end
        if (key_repeat !== 4'h0) begin bad++; $display("FAIL reset_repeat got=%h required=0", key_repeat); end
        rst_n = 1'b1;
        wait_cycles(10);
        total++;
        if (keys_export !== 4'h0) begin bad++; $display("FAIL idle_export got=%h required=0", keys_export); end
    endtask

    task automatic test_single_press;
        key_n[0] = 1'b0;
        push_ev(cyc + D + 3, 4'b0001, 4'h0, 4'h0);
        wait_cycles(12);
        total++;
        if (keys_export !== 4'b0001) begin bad++; $display("FAIL single_press_export got=%h required=1", keys_export); end
        key_n[0] = 1'b1;
        push_ev(cyc + D + 3, 4'h0, 4'b0001, 4'h0);
        wait_cycles(12);
        total += 2;
        if (keys_export !== 4'h0) begin bad++; $display("FAIL single_release_export got=%h required=0", keys_export); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL single_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_bounce;
        key_n[1] = 1'b0;
        wait_cycles(3);
        key_n[1] = 1'b1;
        wait_cycles(1);
        key_n[1] = 1'b0;
        wait_cycles(3);
        key_n[1] = 1'b1;
        wait_cycles(2);
        total++;
        if (keys_export !== 4'h0) begin bad++; $display("FAIL bounce_export got=%h required=0", keys_export); end
        key_n[1] = 1'b0;
        push_ev(cyc + D + 3, 4'b0010, 4'h0, 4'h0);
        wait_cycles(12);
        total += 2;
        if (keys_export !== 4'b0010) begin bad++; $display("FAIL bounce_press_export got=%h required=2", keys_export); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL bounce_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_release_bounce;
        key_n[1] = 1'b1;
        wait_cycles(2);
        key_n[1] = 1'b0;
        wait_cycles(8);
        total++;
        if (keys_export !== 4'b0010) begin bad++; $display("FAIL rel_bounce_export got=%h required=2", keys_export); end
        key_n[1] = 1'b1;
        push_ev(cyc + D + 3, 4'h0, 4'b0010, 4'h0);
        wait_cycles(12);
        total += 2;
        if (keys_export !== 4'h0) begin bad++; $display("FAIL rel_export got=%h required=0", keys_export); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL rel_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_simultaneous;
        key_n = 4'h0;
        push_ev(cyc + D + 3, 4'hF, 4'h0, 4'h0);
        wait_cycles(12);
        total++;
        if (keys_export !== 4'hF) begin bad++; $display("FAIL all_export got=%h required=f", keys_export); end
        key_n = 4'hF;
        push_ev(cyc + D + 3, 4'h0, 4'hF, 4'h0);
        wait_cycles(12);
        total += 2;
        if (keys_export !== 4'h0) begin bad++; $display("FAIL all_release_export got=%h required=0", keys_export); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL all_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        key_n[2] = 1'b0;
        push_ev(cyc + D + 3, 4'b0100, 4'h0, 4'h0);
        wait_cycles(10);
        key_n[0] = 1'b0;
        wait_cycles(4);
        #2 rst_n = 1'b0;
        #1;
        total += 2;
        if (keys_export !== 4'h0) begin bad++; $display("FAIL async_reset_export got=%h required=0", keys_export); end
        if (key_press !== 4'h0) begin bad++; $display("FAIL async_reset_press got=%h required=0", key_press); end
        @(negedge clk);
        rst_n = 1'b1;
        push_ev(cyc + D + 3, 4'b0101, 4'h0, 4'h0);
        wait_cycles(12);
        total++;
        if (keys_export !== 4'b0101) begin bad++; $display("FAIL post_reset_export got=%h required=5", keys_export); end
        key_n = 4'hF;
        push_ev(cyc + D + 3, 4'h0, 4'b0101, 4'h0);
        wait_cycles(12);
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL reset_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_repeat;
        int c;
        key_n[3] = 1'b0;
        c = cyc;
        push_ev(c + D + 3, 4'b1000, 4'h0, 4'h0);
`ifdef KEY_REPEAT_EN
        push_ev(c + D + 13, 4'h0, 4'h0, 4'b1000);
        push_ev(c + D + 16, 4'h0, 4'h0, 4'b1000);
        push_ev(c + D + 19, 4'h0, 4'h0, 4'b1000);
`endif
        wait_cycles(22);
        total++;
        if (keys_export !== 4'b1000) begin bad++; $display("FAIL hold_export got=%h required=8", keys_export); end
        key_n[3] = 1'b1;
        push_ev(cyc + D + 3, 4'h0, 4'b1000, 4'h0);
        wait_cycles(20);
        total += 2;
        if (keys_export !== 4'h0) begin bad++; $display("FAIL hold_release_export got=%h required=0", keys_export); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL repeat_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Fabric-side producer for the HPS keys PIO: takes the raw active-low DE1-SoC push-buttons, synchronizes and debounces them per key, and drives the debounced pressed-level vector into `keys_export` of the Qsys system. Also emits single-cycle press/release event pulses for fabric logic. It is the writer end of the keys PIO the HPS software reads.

## Interface
- `NUM_KEYS`, 4: number of buttons.
- `DEBOUNCE_CYCLES`, 500000: stable cycles required before a level change is accepted (10 ms at 50 MHz); must be ≥2, elaboration error otherwise.
- `REPEAT_DELAY`, 25000000: cycles held before the first repeat pulse (only used with `KEY_REPEAT_EN`).
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses (only used with `KEY_REPEAT_EN`).
- `clk_clk`  input  1  system clock; one clock, everything synchronous to it.
- `reset_reset_n`  input  1  reset, asynchronous, active-low.
- `key_n_i`  input  NUM_KEYS  raw buttons, 0 = pressed, asynchronous to `clk_clk`.
- `keys_export`  output  NUM_KEYS  debounced level, 1 = pressed; connects to the system's `keys_export` input.
- `key_press_o`  output  NUM_KEYS  one-cycle pulse per accepted press.
- `key_release_o`  output  NUM_KEYS  one-cycle pulse per accepted release.
- `key_repeat_o`  output  NUM_KEYS  one-cycle auto-repeat pulse; constant 0 without `KEY_REPEAT_EN`.

## Operation
- Per key: 2-flop synchronizer on `key_n_i`, inverted to active-high `pressed`, feeding an independent FSM with counter of width $clog2(DEBOUNCE_CYCLES).
- States: IDLE (released, stable), PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE: `pressed`=1 → PRESS_WAIT, cnt←0.
- PRESS_WAIT: `pressed`=0 → IDLE (glitch rejected, no pulse); else if cnt==DEBOUNCE_CYCLES-1 → HELD, set level, pulse `key_press_o`; else cnt++.
- HELD: `pressed`=0 → RELEASE_WAIT, cnt←0.
- RELEASE_WAIT: `pressed`=1 → HELD (no pulse); else if cnt==DEBOUNCE_CYCLES-1 → IDLE, clear level, pulse `key_release_o`; else cnt++.
- `keys_export` is registered state (1 in HELD and RELEASE_WAIT), never combinational from input.
- Keys are fully independent; simultaneous presses on several keys produce simultaneous pulses in the same cycle.
- Reset (any time, including mid-debounce): all FSMs → IDLE, counters 0, synchronizers 1 (released), all outputs 0. A key held through reset release is re-debounced and produces a press pulse.

## Timing
- Stable press sampled first at edge E0: synchronizer output seen by FSM at E2 (enter PRESS_WAIT); `keys_export` and `key_press_o` rise after edge E(DEBOUNCE_CYCLES+2).
- Release latency identical; `keys_export` falls together with `key_release_o` pulse.
- Any bounce shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.
- Pulses are exactly one cycle high; no two press pulses without an intervening release pulse on the same key.

## Configuration
- `KEY_REPEAT_EN` defined: in HELD a repeat counter runs; `key_repeat_o` pulses REPEAT_DELAY cycles after entering HELD from PRESS_WAIT, then every REPEAT_PERIOD cycles; counter cleared on leaving HELD and not restarted when returning from RELEASE_WAIT (continues from 0 only after a fresh press). Elaboration error if REPEAT_PERIOD==0.
- Not defined: no repeat counter synthesized, `key_repeat_o` tied to 0.

## Structure
- Package `key_cond_pkg`: FSM state enum, default constant values for DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD.
- Sub-module `key_debounce_fsm` (synchronizer + FSM + counters for one key), instantiated NUM_KEYS times via generate in `key_conditioner`.

## Test plan
- DEBOUNCE_CYCLES=4: key_n_i[0] low and held → keys_export[0]=1 and one key_press_o[0] pulse exactly 6 edges after first sampling edge; other bits stay 0.
- Bounce: key_n_i[1] low 3 cycles, high 1, low 3 → no output change; then low ≥6 → single press pulse.
- Release with bounce: from HELD, key high 2 cycles then low → stays pressed, no release pulse; then high ≥6 → keys_export 0, one release pulse.
- All four keys pressed same cycle → key_press_o=4'hF for exactly one cycle, keys_export=4'hF.
- reset_reset_n asserted mid PRESS_WAIT → outputs 0 immediately (async); after deassert with key still low → press pulse D+3 edges later.
- `KEY_REPEAT_EN`, REPEAT_DELAY=10, REPEAT_PERIOD=3: held key → repeat pulses at 10, 13, 16 cycles after press pulse; release stops them.
